// File: rtl/uart_duplex_core.sv
// Full-duplex UART PHY: independent TX and RX engines, each with its own bit-timing divider.
// RX decides every bit by a 3-sample majority around the bit centre and reports parity/framing/overrun.
module uart_duplex_core #(
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned N_OVS       = 4,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic                 TX,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 RX_PARITY_ERR,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_OVERRUN
);
    localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OvsW  = $clog2(N_OVS);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] TickMax  = TickW'(CLK_DIV - 1);
    localparam logic [OvsW-1:0]  OvsMax   = OvsW'(N_OVS - 1);
    localparam logic [OvsW-1:0]  SmpA     = OvsW'(N_OVS / 2 - 1);
    localparam logic [OvsW-1:0]  SmpB     = OvsW'(N_OVS / 2);
    localparam logic [OvsW-1:0]  SmpC     = OvsW'(N_OVS / 2 + 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
    localparam bit               HasParity = (PARITY_MODE != 0);
    localparam bit               OddParity = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // ---------------------------------------------------------------- TX engine
    tx_state_e            tx_state_q, tx_state_d;
    logic [TickW-1:0]     tx_tick_q, tx_tick_d;
    logic [OvsW-1:0]      tx_ovs_q, tx_ovs_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_ovs_d   = tx_ovs_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        tx_bit_end = (tx_tick_q == TickMax) && (tx_ovs_q == OvsMax);
        if (tx_state_q == TxIdle) begin
            tx_line_d  = 1'b1;
            tx_ready_d = 1'b1;
            tx_tick_d  = '0;
            tx_ovs_d   = '0;
            if (TX_VALID && tx_ready_q) begin
                tx_state_d = TxStart;
                tx_shift_d = TX_DATA;
                tx_par_d   = (^TX_DATA) ^ OddParity;
                tx_line_d  = 1'b0;
                tx_ready_d = 1'b0;
            end
        end else begin
            tx_tick_d = (tx_tick_q == TickMax) ? '0 : tx_tick_q + TickW'(1);
            if (tx_tick_q == TickMax) begin
                tx_ovs_d = (tx_ovs_q == OvsMax) ? '0 : tx_ovs_q + OvsW'(1);
            end
            if (tx_bit_end) begin
                unique case (tx_state_q)
                    TxStart: begin
                        tx_state_d = TxData;
                        tx_bit_d   = '0;
                        tx_line_d  = tx_shift_q[0];
                    end
                    TxData: begin
                        if (tx_bit_q == DataLast) begin
                            tx_bit_d = '0;
                            if (HasParity) begin
                                tx_state_d = TxParity;
                                tx_line_d  = tx_par_q;
                            end else begin
                                tx_state_d = TxStop;
                                tx_line_d  = 1'b1;
                            end
                        end else begin
                            tx_bit_d   = tx_bit_q + BitW'(1);
                            tx_shift_d = tx_shift_q >> 1;
                            tx_line_d  = tx_shift_q[1];
                        end
                    end
                    TxParity: begin
                        tx_state_d = TxStop;
                        tx_bit_d   = '0;
                        tx_line_d  = 1'b1;
                    end
                    TxStop: begin
                        tx_line_d = 1'b1;
                        if (tx_bit_q == StopLast) begin
                            tx_state_d = TxIdle;
                            tx_ready_d = 1'b1;
                        end else begin
                            tx_bit_d = tx_bit_q + BitW'(1);
                        end
                    end
                    default: tx_state_d = TxIdle;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state_q <= TxIdle;
            tx_tick_q  <= '0;
            tx_ovs_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_ovs_q   <= tx_ovs_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign TX       = tx_line_q;
    assign TX_READY = tx_ready_q;

    // ---------------------------------------------------------------- RX engine
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [TickW-1:0]     rx_tick_q, rx_tick_d;
    logic [OvsW-1:0]      rx_ovs_q, rx_ovs_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_smp_q, rx_smp_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_bit_end, rx_decide, rx_maj, rx_hs;
    logic                 rx_done, rx_ferr_new, rx_perr_new;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_ovs_d    = rx_ovs_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_smp_d    = rx_smp_q;
        rx_par_d    = rx_par_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        rx_ovr_d    = rx_ovr_q;
        rx_done     = 1'b0;
        rx_ferr_new = 1'b0;
        rx_perr_new = 1'b0;
        rx_bit_end  = (rx_tick_q == TickMax) && (rx_ovs_q == OvsMax);
        rx_decide   = (rx_tick_q == '0) && (rx_ovs_q == SmpC);
        rx_maj      = (rx_smp_q[0] & rx_smp_q[1]) | ((rx_smp_q[0] | rx_smp_q[1]) & rx_sync_q);
        rx_hs       = rx_valid_q & RX_READY;

        if (rx_state_q == RxIdle) begin
            rx_tick_d = '0;
            rx_ovs_d  = '0;
            // Only a falling edge starts a frame, so a held-low line cannot retrigger.
            if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
        end else begin
            rx_tick_d = (rx_tick_q == TickMax) ? '0 : rx_tick_q + TickW'(1);
            if (rx_tick_q == TickMax) begin
                rx_ovs_d = (rx_ovs_q == OvsMax) ? '0 : rx_ovs_q + OvsW'(1);
            end
            if (rx_tick_q == '0 && rx_ovs_q == SmpA) rx_smp_d[0] = rx_sync_q;
            if (rx_tick_q == '0 && rx_ovs_q == SmpB) rx_smp_d[1] = rx_sync_q;
            unique case (rx_state_q)
                RxStart: begin
                    if (rx_decide && rx_maj) begin
                        rx_state_d = RxIdle;
                    end else if (rx_bit_end) begin
                        rx_state_d = RxData;
                        rx_bit_d   = '0;
                    end
                end
                RxData: begin
                    if (rx_decide) rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_end) begin
                        if (rx_bit_q == DataLast) begin
                            rx_state_d = HasParity ? RxParity : RxStop;
                        end else begin
                            rx_bit_d = rx_bit_q + BitW'(1);
                        end
                    end
                end
                RxParity: begin
                    if (rx_decide) rx_par_d = rx_maj;
                    if (rx_bit_end) rx_state_d = RxStop;
                end
                RxStop: begin
                    // Finish at the stop-bit decision to leave margin for the next start edge.
                    if (rx_decide) begin
                        rx_state_d  = RxIdle;
                        rx_done     = 1'b1;
                        rx_ferr_new = ~rx_maj;
                        rx_perr_new = HasParity && (rx_par_q != ((^rx_shift_q) ^ OddParity));
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end

        if (rx_done && (!rx_valid_q || rx_hs)) begin
            rx_data_d  = rx_shift_q;
            rx_perr_d  = rx_perr_new;
            rx_ferr_d  = rx_ferr_new;
            rx_valid_d = 1'b1;
            rx_ovr_d   = 1'b0;
        end else if (rx_done) begin
            rx_ovr_d = 1'b1;
        end else if (rx_hs) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_tick_q  <= '0;
            rx_ovs_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_smp_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_ovs_q   <= rx_ovs_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_smp_q   <= rx_smp_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign RX_DATA       = rx_data_q;
    assign RX_VALID      = rx_valid_q;
    assign RX_PARITY_ERR = rx_perr_q;
    assign RX_FRAME_ERR  = rx_ferr_q;
    assign RX_OVERRUN    = rx_ovr_q;

endmodule
